// File: rtl/job_sequencer.sv
// Per-job control FSM between external_io and the shapool hasher pool: clears the pool, runs a bounded search, latches the first win.
// Latency: outputs registered; a success sampled in RUN is reported one cycle later.
// No backpressure: the result and READY request are held until result_ack_in, halt_in or a new job_load_in.
module job_sequencer #(
    parameter int              POOL_SIZE_LOG2     = 1,
    parameter int              CLEAR_CYCLES       = 4,
    parameter longint unsigned SEARCH_CYCLES      = 64'd2147483648,
    parameter int              SEARCH_COUNT_WIDTH = 40,
    localparam int             NONCE_WIDTH        = 32 - POOL_SIZE_LOG2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   job_load_in,
    input  logic                   halt_in,
    input  logic                   result_ack_in,
    input  logic                   pool_success_in,
    input  logic [NONCE_WIDTH-1:0] pool_nonce_in,
    output logic                   pool_reset_n_out,
    output logic [31:0]            result_nonce_out,
    output logic                   result_valid_out,
    output logic                   exhausted_out,
    output logic                   ready_out,
    output logic                   busy_out
);

    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CLR_W-1:0]              CLEAR_LAST  = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [SEARCH_COUNT_WIDTH-1:0] SEARCH_LAST = SEARCH_COUNT_WIDTH'(SEARCH_CYCLES - 64'd1);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, FOUND, EXHAUSTED} state_t;

    state_t                        state, state_nxt;
    logic [CLR_W-1:0]              clr_cnt, clr_nxt;
    logic [SEARCH_COUNT_WIDTH-1:0] srch_cnt, srch_nxt;
    logic [31:0]                   nonce_nxt;
    logic                          valid_nxt;
    logic                          exh_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            clr_cnt          <= '0;
            srch_cnt         <= '0;
            result_nonce_out <= '0;
            result_valid_out <= 1'b0;
            exhausted_out    <= 1'b0;
            pool_reset_n_out <= 1'b0;
            ready_out        <= 1'b0;
            busy_out         <= 1'b0;
        end else begin
            state            <= state_nxt;
            clr_cnt          <= clr_nxt;
            srch_cnt         <= srch_nxt;
            result_nonce_out <= nonce_nxt;
            result_valid_out <= valid_nxt;
            exhausted_out    <= exh_nxt;
            // Status outputs decode the next state so they line up with it.
            pool_reset_n_out <= (state_nxt == RUN);
            ready_out        <= (state_nxt == FOUND) || (state_nxt == EXHAUSTED);
            busy_out         <= (state_nxt == CLEAR) || (state_nxt == RUN);
        end
    end

    always_comb begin
        state_nxt = state;
        clr_nxt   = clr_cnt;
        srch_nxt  = srch_cnt;
        nonce_nxt = result_nonce_out;
        valid_nxt = result_valid_out;
        exh_nxt   = exhausted_out;

        if (job_load_in) begin
            state_nxt = CLEAR;
            clr_nxt   = CLEAR_LAST;
            srch_nxt  = '0;
            nonce_nxt = '0;
            valid_nxt = 1'b0;
            exh_nxt   = 1'b0;
        end else if (halt_in) begin
            // Abort keeps the last nonce for host debug; everything else returns to reset values.
            state_nxt = IDLE;
            clr_nxt   = '0;
            srch_nxt  = '0;
            valid_nxt = 1'b0;
            exh_nxt   = 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                CLEAR: begin
                    if (clr_cnt == '0) begin
                        state_nxt = RUN;
                        srch_nxt  = '0;
                    end else begin
                        clr_nxt = clr_cnt - CLR_W'(1);
                    end
                end
                RUN: begin
                    if (pool_success_in) begin
                        state_nxt = FOUND;
                        nonce_nxt = {{POOL_SIZE_LOG2{1'b0}}, pool_nonce_in};
                        valid_nxt = 1'b1;
                    end else if (srch_cnt == SEARCH_LAST) begin
                        state_nxt = EXHAUSTED;
                        exh_nxt   = 1'b1;
                    end else begin
                        srch_nxt = srch_cnt + SEARCH_COUNT_WIDTH'(1);
                    end
                end
                FOUND, EXHAUSTED: begin
                    if (result_ack_in) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_job_sequencer.sv
// Self-checking bench for job_sequencer: directed job sequences with a result scoreboard.
module tb_job_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        job_load_in, halt_in, result_ack_in, pool_success_in;
    logic [30:0] pool_nonce_in;
    logic        pool_reset_n_out;
    logic [31:0] result_nonce_out;
    logic        result_valid_out, exhausted_out, ready_out, busy_out;

    always #5 clk = ~clk;

    job_sequencer #(
        .POOL_SIZE_LOG2    (1),
        .CLEAR_CYCLES      (2),
        .SEARCH_CYCLES     (64'd16),
        .SEARCH_COUNT_WIDTH(40)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .job_load_in     (job_load_in),
        .halt_in         (halt_in),
        .result_ack_in   (result_ack_in),
        .pool_success_in (pool_success_in),
        .pool_nonce_in   (pool_nonce_in),
        .pool_reset_n_out(pool_reset_n_out),
        .result_nonce_out(result_nonce_out),
        .result_valid_out(result_valid_out),
        .exhausted_out   (exhausted_out),
        .ready_out       (ready_out),
        .busy_out        (busy_out)
    );

    typedef struct {
        logic [31:0] nonce;
        logic        valid;
        logic        exh;
    } res_t;

    res_t sb[$];
    res_t mon_r;
    logic prev_ready = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   run_len;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_job();
        job_load_in = 1'b1;
        tick();
        job_load_in = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] nonce, input logic valid, input logic exh);
        res_t e;
        e.nonce = nonce;
        e.valid = valid;
        e.exh   = exh;
        sb.push_back(e);
    endtask

    // Each rising READY request must match the oldest expected result.
    always @(negedge clk) begin
        if (ready_out && !prev_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_r = sb.pop_front();
                chk("sb_nonce", result_nonce_out, mon_r.nonce);
                chk("sb_valid", {31'b0, result_valid_out}, {31'b0, mon_r.valid});
                chk("sb_exh", {31'b0, exhausted_out}, {31'b0, mon_r.exh});
            end
        end
        prev_ready = ready_out;
    end

    task automatic count_run();
        run_len = 0;
        for (int i = 0; i < 100; i++) begin
            if (ready_out) break;
            if (pool_reset_n_out) run_len++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        job_load_in = 1'b0; halt_in = 1'b0; result_ack_in = 1'b0;
        pool_success_in = 1'b0; pool_nonce_in = '0;
        tick(); tick();
        chk("rst_prn", {31'b0, pool_reset_n_out}, 0);
        chk("rst_nonce", result_nonce_out, 0);
        chk("rst_valid", {31'b0, result_valid_out}, 0);
        chk("rst_exh", {31'b0, exhausted_out}, 0);
        chk("rst_ready", {31'b0, ready_out}, 0);
        chk("rst_busy", {31'b0, busy_out}, 0);
        reset_n = 1'b1;
        tick();

        // Job then success eight RUN cycles later.
        pulse_job();
        chk("j1_c1_prn", {31'b0, pool_reset_n_out}, 0);
        chk("j1_c1_busy", {31'b0, busy_out}, 1);
        tick();
        chk("j1_c2_prn", {31'b0, pool_reset_n_out}, 0);
        chk("j1_c2_busy", {31'b0, busy_out}, 1);
        tick();
        chk("j1_run_prn", {31'b0, pool_reset_n_out}, 1);
        chk("j1_run_busy", {31'b0, busy_out}, 1);
        for (int i = 0; i < 7; i++) tick();
        pool_success_in = 1'b1;
        pool_nonce_in   = 31'h091A2B3C;
        push_exp(32'h091A2B3C, 1'b1, 1'b0);
        tick();
        pool_success_in = 1'b0;
        pool_nonce_in   = '0;
        chk("j1_found_ready", {31'b0, ready_out}, 1);
        chk("j1_found_nonce", result_nonce_out, 32'h091A2B3C);
        chk("j1_found_prn", {31'b0, pool_reset_n_out}, 0);
        chk("j1_found_busy", {31'b0, busy_out}, 0);
        result_ack_in = 1'b1;
        tick();
        result_ack_in = 1'b0;
        chk("j1_ack_ready", {31'b0, ready_out}, 0);
        chk("j1_ack_valid", {31'b0, result_valid_out}, 1);

        // No success: exhaustion after 16 RUN cycles.
        pulse_job();
        tick(); tick();
        push_exp(32'h0, 1'b0, 1'b1);
        count_run();
        chk("ex_run_len", run_len, 16);
        chk("ex_ready", {31'b0, ready_out}, 1);
        chk("ex_exh", {31'b0, exhausted_out}, 1);
        chk("ex_valid", {31'b0, result_valid_out}, 0);
        result_ack_in = 1'b1;
        tick();
        result_ack_in = 1'b0;
        chk("ex_ack_ready", {31'b0, ready_out}, 0);
        chk("ex_ack_exh", {31'b0, exhausted_out}, 1);

        // Success ignored in CLEAR, ack ignored in RUN, success on the terminal RUN cycle wins.
        pulse_job();
        pool_success_in = 1'b1;
        pool_nonce_in   = 31'h7FFFFFFF;
        tick();
        pool_success_in = 1'b0;
        chk("clr_succ_prn", {31'b0, pool_reset_n_out}, 0);
        chk("clr_succ_busy", {31'b0, busy_out}, 1);
        chk("clr_succ_valid", {31'b0, result_valid_out}, 0);
        tick();
        chk("t_run_prn", {31'b0, pool_reset_n_out}, 1);
        result_ack_in = 1'b1;
        tick();
        result_ack_in = 1'b0;
        chk("run_ack_busy", {31'b0, busy_out}, 1);
        chk("run_ack_prn", {31'b0, pool_reset_n_out}, 1);
        for (int i = 0; i < 14; i++) tick();
        pool_success_in = 1'b1;
        pool_nonce_in   = 31'h5555AAAA;
        push_exp(32'h5555AAAA, 1'b1, 1'b0);
        tick();
        pool_success_in = 1'b0;
        chk("term_valid", {31'b0, result_valid_out}, 1);
        chk("term_exh", {31'b0, exhausted_out}, 0);
        result_ack_in = 1'b1;
        tick();
        result_ack_in = 1'b0;

        // Reload at counter 7 restarts CLEAR and the search counter.
        pulse_job();
        tick(); tick();
        for (int i = 0; i < 7; i++) tick();
        job_load_in = 1'b1;
        tick();
        job_load_in = 1'b0;
        chk("rl_c1_prn", {31'b0, pool_reset_n_out}, 0);
        chk("rl_c1_busy", {31'b0, busy_out}, 1);
        tick();
        chk("rl_c2_prn", {31'b0, pool_reset_n_out}, 0);
        tick();
        chk("rl_run_prn", {31'b0, pool_reset_n_out}, 1);
        push_exp(32'h0, 1'b0, 1'b1);
        count_run();
        chk("rl_run_len", run_len, 16);
        job_load_in = 1'b1;
        halt_in     = 1'b1;
        tick();
        job_load_in = 1'b0;
        halt_in     = 1'b0;
        chk("jh_busy", {31'b0, busy_out}, 1);
        chk("jh_prn", {31'b0, pool_reset_n_out}, 0);
        chk("jh_ready", {31'b0, ready_out}, 0);
        chk("jh_exh", {31'b0, exhausted_out}, 0);

        // Halt in FOUND keeps the nonce; ack in IDLE does nothing.
        tick(); tick();
        pool_success_in = 1'b1;
        pool_nonce_in   = 31'h0ABCDEF1;
        push_exp(32'h0ABCDEF1, 1'b1, 1'b0);
        tick();
        pool_success_in = 1'b0;
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        chk("halt_ready", {31'b0, ready_out}, 0);
        chk("halt_valid", {31'b0, result_valid_out}, 0);
        chk("halt_nonce", result_nonce_out, 32'h0ABCDEF1);
        chk("halt_busy", {31'b0, busy_out}, 0);
        result_ack_in = 1'b1;
        tick();
        result_ack_in = 1'b0;
        chk("idle_ack_busy", {31'b0, busy_out}, 0);
        chk("idle_ack_ready", {31'b0, ready_out}, 0);
        chk("idle_ack_nonce", result_nonce_out, 32'h0ABCDEF1);

        // Asynchronous reset mid-RUN, then a normal job.
        pulse_job();
        tick(); tick(); tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_prn", {31'b0, pool_reset_n_out}, 0);
        chk("arst_busy", {31'b0, busy_out}, 0);
        chk("arst_nonce", result_nonce_out, 0);
        chk("arst_ready", {31'b0, ready_out}, 0);
        tick();
        reset_n = 1'b1;
        tick();
        pulse_job();
        chk("post_c1_prn", {31'b0, pool_reset_n_out}, 0);
        chk("post_c1_busy", {31'b0, busy_out}, 1);
        tick();
        chk("post_c2_prn", {31'b0, pool_reset_n_out}, 0);
        tick();
        chk("post_run_prn", {31'b0, pool_reset_n_out}, 1);
        tick();

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/job_sequencer.md
# job_sequencer

Per-job control FSM sitting between the SPI `external_io` stage and the `shapool` hasher pool inside the device top level. It restarts the pool when a new job is loaded, runs a bounded search, and latches the first winning nonce. It then drives the device READY request and holds it until the host acknowledges the result or aborts. It replaces the free-running pool and the combinational `success`→`ready` path.

## Interface
Parameters:
- `POOL_SIZE_LOG2`, 1: log2 of hasher count. Defines `NONCE_WIDTH = 32 - POOL_SIZE_LOG2` (localparam).
- `CLEAR_CYCLES`, 4: cycles `pool_reset_n_out` is held low on job start. Must be ≥1.
- `SEARCH_CYCLES`, 2147483648: RUN cycles before the job is declared exhausted. Must be ≥1.
- `SEARCH_COUNT_WIDTH`, 40: search counter width. Must satisfy `SEARCH_CYCLES ≤ 2^SEARCH_COUNT_WIDTH`.

Ports:
- `clk`  in  1: global clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `job_load_in`  in  1: one-cycle pulse; new job config is latched in `external_io`.
- `halt_in`  in  1: one-cycle pulse; host abort.
- `result_ack_in`  in  1: one-cycle pulse; host finished reading the result.
- `pool_success_in`  in  1: `shapool` success flag.
- `pool_nonce_in`  in  NONCE_WIDTH: `shapool` nonce, valid when `pool_success_in`=1.
- `pool_reset_n_out`  out  1: active-low reset/hold to `shapool`.
- `result_nonce_out`  out  32: `{POOL_SIZE_LOG2'b0, captured nonce}`.
- `result_valid_out`  out  1: `result_nonce_out` holds a winning nonce.
- `exhausted_out`  out  1: search ended without success.
- `ready_out`  out  1: request to drive `ready_n_ts_out` low.
- `busy_out`  out  1: high in CLEAR or RUN.

## Operation
- States: IDLE, CLEAR, RUN, FOUND, EXHAUSTED. All outputs are registered.
- Reset (async, any time): IDLE; counters 0; `pool_reset_n_out`=0; `result_nonce_out`=0; all flags 0.
- IDLE: pool held in reset. `job_load_in` → CLEAR.
- CLEAR:
  - `pool_reset_n_out`=0 for exactly CLEAR_CYCLES cycles, then → RUN.
  - On entry: `result_nonce_out`, `result_valid_out`, `exhausted_out` cleared.
  - `pool_success_in` is ignored.
- RUN:
  - `pool_reset_n_out`=1. Search counter starts at 0 and increments each RUN cycle.
  - `pool_success_in`=1 → FOUND; capture `pool_nonce_in`.
  - Else if counter == SEARCH_CYCLES-1 → EXHAUSTED.
- FOUND: `pool_reset_n_out`=0 (pool frozen); `result_valid_out`=1; `ready_out`=1.
- EXHAUSTED: `pool_reset_n_out`=0; `exhausted_out`=1; `ready_out`=1; `result_valid_out`=0.
- `result_ack_in` in FOUND or EXHAUSTED → IDLE; `ready_out` drops.
  - `result_nonce_out`, `result_valid_out` and `exhausted_out` are retained until the next CLEAR entry.
  - Ack in any other state is ignored.
- Priority in every state: `job_load_in` > `halt_in` > `pool_success_in` > exhaustion > `result_ack_in`.
  - `job_load_in` in any state, including CLEAR or RUN, restarts CLEAR with the clear counter reloaded.
  - `halt_in` → IDLE from any state; outputs clear as on reset, except `result_nonce_out`, which is retained.
- Success and terminal count in the same cycle → FOUND.

## Timing
- `job_load_in` high at cycle t: `busy_out`=1 and `pool_reset_n_out`=0 at t+1..t+CLEAR_CYCLES. RUN starts and `pool_reset_n_out`=1 at t+CLEAR_CYCLES+1.
- `pool_success_in` sampled high at RUN cycle s:
  - At s+1: FOUND, `ready_out`=1, `result_valid_out`=1, `result_nonce_out` = nonce sampled at s, `pool_reset_n_out`=0, `busy_out`=0.
  - Latency: 1 cycle.
- Exhaustion: RUN lasts exactly SEARCH_CYCLES cycles. EXHAUSTED is visible on the following cycle.
- `result_ack_in` at cycle a: `ready_out`=0 at a+1.
- Asserting `reset_n` mid-RUN forces all outputs to reset values immediately, without waiting for a clock edge.

## Test plan
Benches use CLEAR_CYCLES=2, SEARCH_CYCLES=16, POOL_SIZE_LOG2=1.
- Reset, then `job_load_in` at t=10 → `pool_reset_n_out` low at 11-12, high at 13; `busy_out`=1 at 11-13. Success at t=20 with nonce 0x1234_5678>>1 = 0x091A2B3C → at t=21 `result_nonce_out`=0x091A2B3C, `ready_out`=1, `result_valid_out`=1.
- No success after the job → RUN spans 16 cycles. `exhausted_out`=1, `ready_out`=1, `result_valid_out`=0. Ack → `ready_out`=0 next cycle, `exhausted_out` still 1.
- Success asserted on the 16th (terminal) RUN cycle → FOUND, not EXHAUSTED. Success asserted during CLEAR → ignored, state stays CLEAR.
- `job_load_in` mid-RUN (counter=7) → CLEAR re-entered, 2 more reset cycles, counter restarts at 0. `job_load_in` and `halt_in` in the same cycle → CLEAR.
- `halt_in` in FOUND → IDLE next cycle, `ready_out`=0, `result_nonce_out` retained. `result_ack_in` in IDLE or RUN → no state change.
- Drop `reset_n` asynchronously mid-RUN → outputs at reset values before the next edge. Deassert, then `job_load_in` → normal CLEAR sequence.
